// File: rtl/bram_heap_sift_ctrl.sv
`timescale 1ns/1ps
// Per-level sift-down controller for a BRAM-tree min-heap.
// Reads both children of the parent's slot, answers the parent with the value
// it must keep, writes the pushed value into the promoted child's slot and
// forwards the push to the next level.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a push-down command from the parent level
// ST_RD     | both child addresses presented to the BRAM
// ST_WAIT   | covering the remaining BRAM read latency
// ST_DECIDE | child data valid; pick min child, answer the parent
// ST_WR     | write pushed value into the promoted child's slot
// ST_FWD    | forward push to the child level, hold until accepted
module bram_heap_sift_ctrl #(
  parameter int DATA_WIDTH   = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_idx,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic                  rsp_swap,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  down_valid,
  input  logic                  down_ready,
  output logic [ADDR_W-1:0]     down_idx,
  output logic [DATA_WIDTH-1:0] down_data,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [ADDR_W-1:0]     ram_addrb,
  output logic                  ram_ena,
  output logic                  ram_enb,
  output logic                  ram_wea,
  output logic                  ram_web,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  output logic                  ram_regcea,
  output logic                  ram_regceb,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_WAIT, ST_DECIDE, ST_WR, ST_FWD
  } state_t;

  localparam logic [DATA_WIDTH-1:0] KEY_INF = '1;
  localparam logic [ADDR_W:0]       DEPTH_C = (ADDR_W+1)'(RAM_DEPTH);
  localparam int                    CNT_W   = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  state_t                  state_q, state_d;
  logic                    live_q;
  logic [ADDR_W-1:0]       l_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    leaf_q, r_oob_q, sel_r_q;
  logic [CNT_W-1:0]        wait_q;

  logic [ADDR_W:0]         l_nxt, r_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_WIDTH-1:0]   left_v, right_v, min_v;
  logic                    sel_r, promote, cmd_fire;

  // Child indices are one bit wider so the leaf / out-of-range test is exact.
  assign l_nxt    = {cmd_idx, 1'b0};
  assign r_nxt    = {cmd_idx, 1'b1};
  assign r_addr   = l_q | ADDR_W'(1);
  assign cmd_fire = cmd_valid & cmd_ready;

  // Missing children read as +inf; ties keep the left child.
  assign left_v  = leaf_q ? KEY_INF : ram_douta;
  assign right_v = (leaf_q | r_oob_q) ? KEY_INF : ram_doutb;
  assign sel_r   = right_v < left_v;
  assign min_v   = sel_r ? right_v : left_v;
  assign promote = min_v < data_q;

  assign busy       = (state_q != ST_IDLE);
  assign ram_regcea = live_q;
  assign ram_regceb = live_q;

  // State register, captured command and read-latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      l_q     <= '0;
      data_q  <= '0;
      leaf_q  <= 1'b0;
      r_oob_q <= 1'b0;
      sel_r_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (cmd_fire) begin
        l_q     <= l_nxt[ADDR_W-1:0];
        data_q  <= cmd_data;
        leaf_q  <= (l_nxt >= DEPTH_C);
        r_oob_q <= (r_nxt >= DEPTH_C);
      end
      if (state_q == ST_RD) begin
        wait_q <= WAIT_LOAD;
      end else if (state_q == ST_WAIT) begin
        wait_q <= wait_q - CNT_W'(1);
      end
      if (state_q == ST_DECIDE) begin
        sel_r_q <= sel_r;
      end
    end
  end

  // Next-state decode and all handshake / BRAM port outputs.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_swap   = 1'b0;
    rsp_data   = '0;
    down_valid = 1'b0;
    down_idx   = '0;
    down_data  = '0;
    ram_addra  = '0;
    ram_addrb  = '0;
    ram_ena    = 1'b0;
    ram_enb    = 1'b0;
    ram_wea    = 1'b0;
    ram_web    = 1'b0;
    ram_dina   = '0;
    ram_dinb   = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = live_q;
        if (cmd_fire) begin
          state_d = (l_nxt >= DEPTH_C) ? ST_DECIDE : ST_RD;
        end
      end
      ST_RD: begin
        ram_ena   = 1'b1;
        ram_addra = l_q;
        ram_enb   = ~r_oob_q;
        ram_addrb = r_addr;
        state_d   = (READ_LATENCY > 1) ? ST_WAIT : ST_DECIDE;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        rsp_valid = 1'b1;
        if (promote) begin
          rsp_swap = 1'b1;
          rsp_data = min_v;
          state_d  = ST_WR;
        end else begin
          rsp_data = data_q;
          state_d  = ST_IDLE;
        end
      end
      ST_WR: begin
        if (sel_r_q) begin
          ram_enb   = 1'b1;
          ram_web   = 1'b1;
          ram_addrb = r_addr;
          ram_dinb  = data_q;
        end else begin
          ram_ena   = 1'b1;
          ram_wea   = 1'b1;
          ram_addra = l_q;
          ram_dina  = data_q;
        end
        state_d = ST_FWD;
      end
      ST_FWD: begin
        down_valid = 1'b1;
        down_idx   = sel_r_q ? r_addr : l_q;
        down_data  = data_q;
        if (down_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_heap_sift_ctrl.sv
`timescale 1ns/1ps
// Bench for bram_heap_sift_ctrl: two instances (HIGH_PERFORMANCE 1024-deep,
// LOW_LATENCY 8-deep) each driving a behavioural read-first BRAM, compared
// against a shadow heap level computed from the sift-down rules.
module tb_bram_heap_sift_ctrl;

  localparam int DW  = 18;
  localparam int DA  = 1024;
  localparam int AWA = 10;
  localparam int DB  = 8;
  localparam int AWB = 3;
  localparam logic [DW-1:0] INF = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cmd_valid = 1'b0;
  logic           sel = 1'b0;
  logic           down_ready = 1'b1;
  logic [AWA-1:0] cmd_idx = '0;
  logic [DW-1:0]  cmd_data = '0;
  int n_chk = 0;
  int n_err = 0;

  logic a_cmd_valid, b_cmd_valid;
  assign a_cmd_valid = cmd_valid & ~sel;
  assign b_cmd_valid = cmd_valid & sel;

  logic a_cmd_ready, a_rsp_valid, a_rsp_swap, a_down_valid, a_ena, a_enb, a_wea, a_web, a_regcea, a_regceb, a_busy;
  logic [DW-1:0]  a_rsp_data, a_down_data, a_dina, a_dinb, a_douta, a_doutb, a_p1a, a_p1b;
  logic [AWA-1:0] a_down_idx, a_addra, a_addrb;
  logic b_cmd_ready, b_rsp_valid, b_rsp_swap, b_down_valid, b_ena, b_enb, b_wea, b_web, b_regcea, b_regceb, b_busy;
  logic [DW-1:0]  b_rsp_data, b_down_data, b_dina, b_dinb, b_douta, b_doutb;
  logic [AWB-1:0] b_down_idx, b_addra, b_addrb;

  bram_heap_sift_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DA), .READ_LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_swap(a_rsp_swap), .rsp_data(a_rsp_data),
    .down_valid(a_down_valid), .down_ready(down_ready), .down_idx(a_down_idx), .down_data(a_down_data),
    .ram_addra(a_addra), .ram_addrb(a_addrb), .ram_ena(a_ena), .ram_enb(a_enb),
    .ram_wea(a_wea), .ram_web(a_web), .ram_dina(a_dina), .ram_dinb(a_dinb),
    .ram_regcea(a_regcea), .ram_regceb(a_regceb), .ram_douta(a_douta), .ram_doutb(a_doutb),
    .busy(a_busy)
  );

  bram_heap_sift_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DB), .READ_LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_idx(cmd_idx[AWB-1:0]), .cmd_data(cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_swap(b_rsp_swap), .rsp_data(b_rsp_data),
    .down_valid(b_down_valid), .down_ready(down_ready), .down_idx(b_down_idx), .down_data(b_down_data),
    .ram_addra(b_addra), .ram_addrb(b_addrb), .ram_ena(b_ena), .ram_enb(b_enb),
    .ram_wea(b_wea), .ram_web(b_web), .ram_dina(b_dina), .ram_dinb(b_dinb),
    .ram_regcea(b_regcea), .ram_regceb(b_regceb), .ram_douta(b_douta), .ram_doutb(b_doutb),
    .busy(b_busy)
  );

  // Outputs of whichever instance the current command targets.
  logic m_cmd_ready, m_rsp_valid, m_rsp_swap, m_down_valid, m_ena, m_enb, m_wea, m_web, m_busy;
  logic [DW-1:0]  m_rsp_data, m_down_data, m_dina, m_dinb;
  logic [AWA-1:0] m_down_idx, m_addra, m_addrb;
  assign m_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
  assign m_rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
  assign m_rsp_swap   = sel ? b_rsp_swap   : a_rsp_swap;
  assign m_rsp_data   = sel ? b_rsp_data   : a_rsp_data;
  assign m_down_valid = sel ? b_down_valid : a_down_valid;
  assign m_down_idx   = sel ? {{(AWA-AWB){1'b0}}, b_down_idx} : a_down_idx;
  assign m_down_data  = sel ? b_down_data  : a_down_data;
  assign m_ena        = sel ? b_ena : a_ena;
  assign m_enb        = sel ? b_enb : a_enb;
  assign m_wea        = sel ? b_wea : a_wea;
  assign m_web        = sel ? b_web : a_web;
  assign m_addra      = sel ? {{(AWA-AWB){1'b0}}, b_addra} : a_addra;
  assign m_addrb      = sel ? {{(AWA-AWB){1'b0}}, b_addrb} : a_addrb;
  assign m_dina       = sel ? b_dina : a_dina;
  assign m_dinb       = sel ? b_dinb : a_dinb;
  assign m_busy       = sel ? b_busy : a_busy;

  // Behavioural read-first BRAMs plus a bench-side preload port.
  logic [DW-1:0]  mem_a [DA];
  logic [DW-1:0]  mem_b [DB];
  logic [DW-1:0]  ref_a [DA];
  logic [DW-1:0]  ref_b [DB];
  logic           pk_en = 1'b0;
  logic           pk_b = 1'b0;
  logic [AWA-1:0] pk_addr = '0;
  logic [DW-1:0]  pk_val = '0;

  always @(posedge clk) begin
    if (pk_en && !pk_b) mem_a[pk_addr] <= pk_val;
    if (pk_en && pk_b)  mem_b[pk_addr[AWB-1:0]] <= pk_val;
    if (a_ena) begin
      if (a_wea) mem_a[a_addra] <= a_dina;
      a_p1a <= mem_a[a_addra];
    end
    if (a_enb) begin
      if (a_web) mem_a[a_addrb] <= a_dinb;
      a_p1b <= mem_a[a_addrb];
    end
    if (a_regcea) a_douta <= a_p1a;
    if (a_regceb) a_doutb <= a_p1b;
    if (b_ena) begin
      if (b_wea) mem_b[b_addra] <= b_dina;
      b_douta <= mem_b[b_addra];
    end
    if (b_enb) begin
      if (b_web) mem_b[b_addrb] <= b_dinb;
      b_doutb <= mem_b[b_addrb];
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_key();
    if ($urandom_range(0, 4) == 0) return INF;
    return DW'($urandom_range(0, 15));
  endfunction

  function automatic logic [DW-1:0] ref_rd(input bit s, input int a);
    return s ? ref_b[a] : ref_a[a];
  endfunction

  function automatic logic [DW-1:0] mem_rd(input bit s, input int a);
    return s ? mem_b[a] : mem_a[a];
  endfunction

  // Called on a negedge; returns on the following negedge.
  task automatic poke(input bit s, input int a, input logic [DW-1:0] v);
    pk_en = 1'b1; pk_b = s; pk_addr = AWA'(a); pk_val = v;
    if (s) ref_b[a] = v; else ref_a[a] = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // One push-down command; cycle k is the k-th negedge after the handshake edge.
  task automatic run_cmd(input bit s, input int idx, input logic [DW-1:0] data, input int stall);
    int depth, rl, lat, end_exp, end_c, rsp_n, rsp_c, wr_n, fwd_n, stray, child;
    int l_i, r_i;
    bit leaf, sel_r, swap;
    logic [DW-1:0] lv, rv, mv, rsp_d, dn_data, wr_din;
    logic [AWA-1:0] dn_idx, wr_addr;
    logic rsp_sw, wr_port;
    depth = s ? DB : DA;
    rl    = s ? 1 : 2;
    l_i   = 2 * idx;
    r_i   = 2 * idx + 1;
    leaf  = (l_i >= depth);
    lv    = leaf ? INF : ref_rd(s, l_i);
    rv    = (r_i >= depth) ? INF : ref_rd(s, r_i);
    sel_r = (rv < lv);
    mv    = sel_r ? rv : lv;
    swap  = (mv < data);
    child = sel_r ? r_i : l_i;
    lat   = leaf ? 1 : rl + 1;
    end_exp = swap ? lat + 3 + stall : lat + 1;
    end_c = -1; rsp_n = 0; rsp_c = -1; wr_n = 0; fwd_n = 0; stray = 0;
    rsp_sw = 1'bx; rsp_d = '0; dn_idx = '0; dn_data = '0; wr_din = '0; wr_addr = '0; wr_port = 1'b0;

    sel = s; cmd_idx = AWA'(idx); cmd_data = data; down_ready = (stall == 0);
    #1;
    chk("ready_before_cmd", m_cmd_ready, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (m_rsp_valid) begin
        rsp_n++; rsp_c = cyc; rsp_sw = m_rsp_swap; rsp_d = m_rsp_data;
      end
      if (cyc == 1 && !leaf) begin
        chk("rd_ena", {m_ena, m_wea}, 2'b10);
        chk("rd_addra", m_addra, l_i);
        chk("rd_enb", {m_enb, m_web}, 2'b10);
        chk("rd_addrb", m_addrb, r_i);
      end
      if (m_wea || m_web) begin
        wr_n++; wr_port = m_web;
        wr_addr = m_web ? m_addrb : m_addra;
        wr_din  = m_web ? m_dinb : m_dina;
        if (m_ena && m_enb) stray++;
      end else if ((m_ena || m_enb) && (leaf || cyc != 1)) begin
        stray++;
      end
      if (m_down_valid) begin
        if (fwd_n == 0) begin
          dn_idx = m_down_idx; dn_data = m_down_data;
        end else begin
          chk("fwd_idx_stable", m_down_idx, dn_idx);
          chk("fwd_data_stable", m_down_data, dn_data);
          chk("fwd_busy_ready", {m_busy, m_cmd_ready}, 2'b10);
        end
        fwd_n++;
        if (fwd_n > stall) down_ready = 1'b1;
      end
      if (m_cmd_ready) begin
        end_c = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_count", rsp_n, 1);
    chk("rsp_latency", rsp_c, lat);
    chk("rsp_swap", rsp_sw, swap);
    chk("rsp_data", rsp_d, swap ? mv : data);
    chk("write_count", wr_n, swap ? 1 : 0);
    chk("fwd_cycles", fwd_n, swap ? stall + 1 : 0);
    chk("stray_enable", stray, 0);
    chk("idle_cycle", end_c, end_exp);
    if (swap) begin
      chk("wr_port", wr_port, sel_r);
      chk("wr_addr", wr_addr, child);
      chk("wr_data", wr_din, data);
      chk("down_idx", dn_idx, child);
      chk("down_data", dn_data, data);
      if (s) ref_b[child] = data; else ref_a[child] = data;
    end
    if (!leaf) begin
      chk("mem_left", mem_rd(s, l_i), ref_rd(s, l_i));
      chk("mem_right", mem_rd(s, r_i), ref_rd(s, r_i));
    end
    down_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {a_cmd_ready, a_busy, a_regcea, a_rsp_valid, a_down_valid, a_ena, a_enb}, 0);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_reset_ready", {a_cmd_ready, b_cmd_ready, a_regcea, b_regceb, a_busy}, 5'b11110);

    for (int i = 0; i < DA; i++) poke(1'b0, i, rnd_key());
    for (int i = 0; i < DB; i++) poke(1'b1, i, rnd_key());

    // Left child promoted, written, forwarded.
    poke(1'b0, 6, 5); poke(1'b0, 7, 9);
    run_cmd(1'b0, 3, 7, 0);
    chk("bram6_after", mem_a[6], 7);
    // Pushed value already smallest.
    poke(1'b0, 8, 8); poke(1'b0, 9, 9);
    run_cmd(1'b0, 4, 7, 0);
    // Tie prefers left; equality never promotes.
    poke(1'b0, 10, 4); poke(1'b0, 11, 4);
    run_cmd(1'b0, 5, 6, 0);
    poke(1'b0, 10, 4); poke(1'b0, 11, 4);
    run_cmd(1'b0, 5, 4, 0);
    // Leaf node in the 8-deep level.
    run_cmd(1'b1, 4, 3, 0);
    // Right child promoted with a stalled child level.
    poke(1'b0, 12, 2); poke(1'b0, 13, 1);
    run_cmd(1'b0, 6, 9, 5);
    // +inf pushed over +inf children.
    poke(1'b0, 14, INF); poke(1'b0, 15, INF);
    run_cmd(1'b0, 7, INF, 0);

    // Reset during the read-latency wait drops the op.
    poke(1'b0, 20, 1); poke(1'b0, 21, 2);
    sel = 1'b0; cmd_idx = 10; cmd_data = 9; down_ready = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_in_wait", {a_busy, a_rsp_valid, a_down_valid, a_ena, a_enb, a_wea, a_web, a_cmd_ready, a_regcea, a_regceb}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ready_after_reset", {a_cmd_ready, b_cmd_ready}, 2'b11);
    chk("dropped_no_write", mem_a[20], 1);
    poke(1'b1, 2, 1); poke(1'b1, 3, 6);
    run_cmd(1'b1, 1, 7, 0);
    run_cmd(1'b0, 10, 9, 1);

    for (int n = 0; n < 150; n++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      run_cmd(s, s ? $urandom_range(0, DB - 1) : $urandom_range(0, DA - 1), rnd_key(), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
